serial_parity_framer: RTL and testbench
=======================================

Name: serial_parity_framer

Overview:
- Parametrised serial parity unit. Consumes one bit per qualified clock, groups bits into DATA_W-bit frames, and produces an even or odd parity bit per frame.
- In check mode it consumes one extra received parity bit after the frame, flags mismatches and counts errors.
- Sits behind any bit-serial source in the A3 sequential blocks; successor to the fixed 3-bit odd-parity FSM.

Parameters:
- DATA_W, 8: data bits per frame; legal range >= 1.
- CNT_W, 4: width of the saturating error counter; legal range >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- bit_in, input, 1: serial data bit.
- bit_valid, input, 1: bit_in is accepted on a rising edge only when this is 1.
- odd_mode, input, 1: 1 = odd parity, 0 = even parity. Sampled at the first bit of a frame.
- check_en, input, 1: 1 = frame is followed by a received parity bit to check. Sampled at the first bit of a frame.
- err_clr, input, 1: synchronous clear of err_count.
- parity_out, output, 1: computed parity of the last completed frame; held until the next frame_done.
- frame_done, output, 1: one-cycle pulse when a frame completes.
- parity_err, output, 1: one-cycle pulse, coincident with frame_done, on a check mismatch.
- err_count, output, CNT_W: saturating count of parity_err pulses.
- busy, output, 1: frame in progress (bit count != 0 or state S_CHECK).

Behaviour:
- Reset (reset=1 at a rising edge):
  - State S_DATA, bit counter 0, running parity 0.
  - All outputs 0, including err_count and parity_out.
  - reset has priority over every other input. A partial frame is discarded and produces no frame_done.
- Acceptance:
  - A bit is accepted on an edge with bit_valid=1 and reset=0.
  - Idle cycles (bit_valid=0) change no state; gaps of any length are legal.
- Mode latch:
  - odd_mode and check_en are registered on the edge accepting bit 0 of a frame.
  - Changes to either input mid-frame have no effect until the next frame.
- S_DATA:
  - Each accepted bit updates running parity p ^= bit_in and increments the counter.
  - The frame completes on the edge accepting the DATA_W-th bit. Expected parity E = (XOR of the DATA_W bits) XOR odd_latched.
  - Even mode: E makes the total count of ones (data + E) even. Odd mode: E makes it odd.
  - If check_en_latched=0: on that same edge, parity_out<=E and frame_done<=1. Counter and p clear; stay in S_DATA.
  - If check_en_latched=1: E is stored, counter clears, go to S_CHECK. No frame_done yet.
- S_CHECK:
  - The next accepted bit is the received parity bit R.
  - On that edge: parity_out<=E, frame_done<=1, parity_err<=(R!=E). Return to S_DATA with p=0.
- Pulses:
  - frame_done and parity_err are registered. They are high for exactly one clock following the completing edge, then return to 0 even if bit_valid stays low.
- Back-to-back frames: bit 0 of the next frame may be accepted on the edge immediately after completion, with no bubble.
- err_count:
  - Increments by 1 on each edge that sets parity_err, and saturates at 2^CNT_W-1.
  - err_clr=1 forces 0. If an error and err_clr occur on the same edge, clear wins and the result is 0.
- DATA_W=1 boundary: a frame completes on every accepted bit (check mode: every second bit).
- Latency: one clock from the completing edge to visible frame_done, parity_out and parity_err.

Decomposition:
- Package parity_pkg:
  - State typedef {S_DATA, S_CHECK}.
  - Mode constants PAR_EVEN=0, PAR_ODD=1.
  - Function for the counter width, clog2(DATA_W+1).
- Sub-module sat_counter (parameter CNT_W; ports clk, reset, inc, clr, count) for err_count; clear has priority over increment.
- Counter/parity FSM stays in the top module.

Test Plan:
- Gen, even, DATA_W=8: bits 1,0,1,1,0,0,1,0 (4 ones), bit_valid=1 continuous -> frame_done high exactly one cycle after the 8th edge, parity_out=0. Same bits in odd mode -> parity_out=1.
- Check, odd: data 0,0,0,0,0,1,1,1 then R=0 -> parity_err=0, err_count=0. Repeat with R=1 -> parity_err pulses once, err_count=1.
- Gaps: frame 1,1,1,0,0,0,0,0 with 3 idle cycles between every bit -> even parity_out=1; frame_done only after the last valid bit; busy stays 1 throughout the gaps.
- Saturation with CNT_W=4: 17 mismatched check frames -> err_count stops at 15. Then err_clr asserted on the edge of an 18th error -> err_count=0.
- Reset after 5 accepted bits -> no frame_done and busy=0. The next full frame 1,0,0,0,0,0,0,0 in even mode -> parity_out=1, unaffected by discarded bits.
- Mode held per frame: odd_mode toggled 0->1 at bit 4 of frame 1,1,0,0,0,0,0,0 -> even result parity_out=0. The following frame uses odd_mode=1.

Source files
------------

// File: rtl/serial_parity_framer_pkg.sv
// rtl/serial_parity_framer_pkg.sv - shared types and helpers for the serial parity framer
//
// Purpose: FSM state type, parity mode constants and the bit-counter width helper.
package parity_pkg;

  typedef enum logic {
    S_DATA  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Counter must hold 0..DATA_W; width is clog2(DATA_W+1), never below 1.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_parity_framer_if.sv
// rtl/serial_parity_framer_if.sv - bit-serial input and frame result bundle
//
// Purpose: groups the framer's serial input, mode controls and frame results.
// Ports (as interface signals):
//   bit_in, bit_valid     serial data bit and its qualifier
//   odd_mode, check_en    per-frame mode controls, latched at bit 0
//   err_clr               synchronous clear of err_count
//   parity_out            parity of the last completed frame
//   frame_done            one-cycle frame completion pulse
//   parity_err            one-cycle check mismatch pulse
//   err_count             saturating mismatch count
//   busy                  frame in progress
// master drives the serial side; slave is the framer.
interface serial_parity_framer_if #(
  parameter int CNT_W = 4
);
  logic             bit_in;
  logic             bit_valid;
  logic             odd_mode;
  logic             check_en;
  logic             err_clr;
  logic             parity_out;
  logic             frame_done;
  logic             parity_err;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  modport master (
    output bit_in, bit_valid, odd_mode, check_en, err_clr,
    input  parity_out, frame_done, parity_err, err_count, busy
  );

  modport slave (
    input  bit_in, bit_valid, odd_mode, check_en, err_clr,
    output parity_out, frame_done, parity_err, err_count, busy
  );
endinterface

// File: rtl/serial_parity_framer_sat_counter.sv
// rtl/serial_parity_framer_sat_counter.sv - saturating up counter with priority clear
//
// Purpose: counts inc pulses, holding at all-ones; clr beats inc on the same edge.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   inc    increment request
//   clr    synchronous clear, priority over inc
//   count  current count
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_parity_framer.sv
// rtl/serial_parity_framer.sv - bit-serial parity generator/checker with error count
//
// Purpose: groups accepted bits into DATA_W-bit frames, produces even/odd parity
// per frame and, in check mode, compares a trailing received parity bit.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    serial_parity_framer_if slave (serial input, controls, frame results)
module serial_parity_framer
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input logic                  clk,
  input logic                  reset,
  serial_parity_framer_if.slave bus
);

  localparam int            CW   = cnt_width(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          par, par_n;
  logic          odd_l, odd_l_n;
  logic          chk_l, chk_l_n;
  logic          exp_par, exp_par_n;
  logic          par_out, par_out_n;
  logic          done, done_n;
  logic          perr, perr_n;

  logic          first;
  logic          odd_eff;
  logic          chk_eff;
  logic          par_acc;
  logic          e_par;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_DATA;
      cnt     <= '0;
      par     <= 1'b0;
      odd_l   <= PAR_EVEN;
      chk_l   <= 1'b0;
      exp_par <= 1'b0;
      par_out <= 1'b0;
      done    <= 1'b0;
      perr    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      par     <= par_n;
      odd_l   <= odd_l_n;
      chk_l   <= chk_l_n;
      exp_par <= exp_par_n;
      par_out <= par_out_n;
      done    <= done_n;
      perr    <= perr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    par_n     = par;
    odd_l_n   = odd_l;
    chk_l_n   = chk_l;
    exp_par_n = exp_par;
    par_out_n = par_out;
    done_n    = 1'b0;
    perr_n    = 1'b0;

    // On bit 0 the latched modes are not yet valid, so use the live inputs;
    // this also covers DATA_W=1 where the first bit is also the last.
    first   = (cnt == '0);
    odd_eff = first ? bus.odd_mode : odd_l;
    chk_eff = first ? bus.check_en : chk_l;
    par_acc = par ^ bus.bit_in;
    e_par   = par_acc ^ odd_eff;

    if (bus.bit_valid) begin
      case (state)
        S_DATA: begin
          if (first) begin
            odd_l_n = bus.odd_mode;
            chk_l_n = bus.check_en;
          end
          if (cnt == LAST) begin
            cnt_n = '0;
            par_n = 1'b0;
            if (chk_eff) begin
              exp_par_n = e_par;
              state_n   = S_CHECK;
            end else begin
              par_out_n = e_par;
              done_n    = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
            par_n = par_acc;
          end
        end
        S_CHECK: begin
          par_out_n = exp_par;
          done_n    = 1'b1;
          perr_n    = (bus.bit_in != exp_par);
          state_n   = S_DATA;
        end
        default: state_n = S_DATA;
      endcase
    end
  end

  assign bus.parity_out = par_out;
  assign bus.frame_done = done;
  assign bus.parity_err = perr;
  assign bus.busy       = (cnt != '0) || (state == S_CHECK);

  // Increment on the same edge that registers parity_err.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (perr_n),
    .clr  (bus.err_clr),
    .count(bus.err_count)
  );

endmodule

// File: tb/tb_serial_parity_framer.sv
// tb/tb_serial_parity_framer.sv - self-checking bench for serial_parity_framer
module tb_serial_parity_framer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_parity_framer_if #(.CNT_W(4)) bus ();
  serial_parity_framer_if #(.CNT_W(4)) bus1 ();

  serial_parity_framer #(.DATA_W(8), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  serial_parity_framer #(.DATA_W(1), .CNT_W(4)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1.slave)
  );

  typedef struct packed {
    logic       par;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_cnt;
  logic m_par;
  logic m_odd;
  logic m_chk;
  logic m_incheck;
  logic m_exp;
  int   m_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_par = 0; m_odd = 0; m_chk = 0; m_incheck = 0; m_exp = 0; m_errs = 0;
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.bit_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock on the main DUT; the model predicts, the result is pushed to q.
  task automatic step(input logic b, input logic v);
    logic e;
    logic err;
    exp_t ex;
    err = 1'b0;
    if (v) begin
      if (!m_incheck) begin
        if (m_cnt == 0) begin
          m_odd = bus.odd_mode;
          m_chk = bus.check_en;
        end
        m_par = m_par ^ b;
        m_cnt++;
        if (m_cnt == 8) begin
          e = m_par ^ m_odd;
          m_cnt = 0;
          m_par = 1'b0;
          if (m_chk) begin
            m_incheck = 1'b1;
            m_exp = e;
          end else begin
            ex.par = e; ex.err = 1'b0; ex.cnt = 4'(m_errs);
            q.push_back(ex);
          end
        end
      end else begin
        err = (b != m_exp);
        m_incheck = 1'b0;
      end
    end
    if (bus.err_clr) m_errs = 0;
    else if (err && m_errs < 15) m_errs++;
    if (v && !m_incheck && err) begin
      ex.par = m_exp; ex.err = 1'b1; ex.cnt = 4'(m_errs);
      q.push_back(ex);
    end else if (v && !m_incheck && m_cnt == 0 && m_chk && !err && q.size() == 0 && b == m_exp) begin
      ex.par = m_exp; ex.err = 1'b0; ex.cnt = 4'(m_errs);
      q.push_back(ex);
    end
    bus.bit_in = b;
    bus.bit_valid = v;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    chk("frame_done", bus.frame_done, (q.size() > 0));
    if (q.size() > 0) begin
      ex = q.pop_front();
      chk("parity_out", bus.parity_out, ex.par);
      chk("parity_err", bus.parity_err, ex.err);
    end else begin
      chk("parity_err_idle", bus.parity_err, 1'b0);
    end
    chk("err_count", bus.err_count, m_errs);
    chk("busy", bus.busy, (m_cnt != 0) || m_incheck);
  endtask

  task automatic send_frame(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) step(bits[i], 1'b1);
  endtask

  task automatic step1(input logic b);
    bus1.bit_in = b;
    bus1.bit_valid = 1'b1;
    @(posedge clk); #1;
    bus1.bit_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] fb;
    bus.bit_in = 0; bus.bit_valid = 0; bus.odd_mode = 0; bus.check_en = 0; bus.err_clr = 0;
    bus1.bit_in = 0; bus1.bit_valid = 0; bus1.odd_mode = 0; bus1.check_en = 0; bus1.err_clr = 0;
    model_clear();

    // Reset state
    do_reset();
    chk("rst_parity_out", bus.parity_out, 1'b0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_parity_err", bus.parity_err, 1'b0);
    chk("rst_err_count", bus.err_count, 4'd0);
    chk("rst_busy", bus.busy, 1'b0);

    // Generate, even then odd, continuous valid
    bus.odd_mode = 0; bus.check_en = 0;
    send_frame(8'b10110010);
    chk("gen_even_par", bus.parity_out, 1'b0);
    chk("gen_even_done", bus.frame_done, 1'b1);
    bus.odd_mode = 1;
    send_frame(8'b10110010);
    chk("gen_odd_par", bus.parity_out, 1'b1);
    step(1'b0, 1'b0);
    chk("gen_odd_hold", bus.parity_out, 1'b1);

    // Check mode, odd: match then mismatch
    bus.odd_mode = 1; bus.check_en = 1;
    send_frame(8'b00000111);
    chk("chk_busy_wait", bus.busy, 1'b1);
    step(1'b0, 1'b1);
    chk("chk_ok_err", bus.parity_err, 1'b0);
    chk("chk_ok_cnt", bus.err_count, 4'd0);
    send_frame(8'b00000111);
    step(1'b1, 1'b1);
    chk("chk_bad_err", bus.parity_err, 1'b1);
    chk("chk_bad_cnt", bus.err_count, 4'd1);
    step(1'b0, 1'b0);
    chk("chk_err_pulse", bus.parity_err, 1'b0);

    // Gaps of 3 idle cycles between bits, even mode
    bus.odd_mode = 0; bus.check_en = 0;
    fb = 8'b11100000;
    for (int i = 7; i >= 0; i--) begin
      step(fb[i], 1'b1);
      if (i != 0) for (int g = 0; g < 3; g++) step(1'b0, 1'b0);
    end
    chk("gap_par", bus.parity_out, 1'b1);
    chk("gap_done", bus.frame_done, 1'b1);

    // Saturation of err_count
    bus.err_clr = 1;
    step(1'b0, 1'b0);
    bus.err_clr = 0;
    chk("clr_cnt", bus.err_count, 4'd0);
    bus.odd_mode = 0; bus.check_en = 1;
    for (int k = 0; k < 17; k++) begin
      send_frame(8'b00000000);
      step(1'b1, 1'b1);
    end
    chk("sat_cnt", bus.err_count, 4'd15);
    send_frame(8'b00000000);
    bus.err_clr = 1;
    step(1'b1, 1'b1);
    bus.err_clr = 0;
    chk("clr_win_err", bus.parity_err, 1'b1);
    chk("clr_win_cnt", bus.err_count, 4'd0);

    // Reset discards a partial frame
    bus.check_en = 0; bus.odd_mode = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    do_reset();
    chk("prst_done", bus.frame_done, 1'b0);
    chk("prst_busy", bus.busy, 1'b0);
    send_frame(8'b10000000);
    chk("prst_par", bus.parity_out, 1'b1);

    // Mode latched per frame
    bus.odd_mode = 0;
    fb = 8'b11000000;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) bus.odd_mode = 1;
      step(fb[i], 1'b1);
    end
    chk("mode_hold_par", bus.parity_out, 1'b0);
    send_frame(8'b11000000);
    chk("mode_next_par", bus.parity_out, 1'b1);

    // DATA_W=1 boundary on the second instance
    bus1.odd_mode = 0; bus1.check_en = 0;
    step1(1'b1);
    chk("w1_done_a", bus1.frame_done, 1'b1);
    chk("w1_par_a", bus1.parity_out, 1'b1);
    step1(1'b0);
    chk("w1_done_b", bus1.frame_done, 1'b1);
    chk("w1_par_b", bus1.parity_out, 1'b0);
    bus1.odd_mode = 1;
    step1(1'b1);
    chk("w1_odd_par", bus1.parity_out, 1'b0);
    bus1.odd_mode = 0; bus1.check_en = 1;
    step1(1'b1);
    chk("w1_chk_wait", bus1.frame_done, 1'b0);
    chk("w1_chk_busy", bus1.busy, 1'b1);
    step1(1'b0);
    chk("w1_chk_done", bus1.frame_done, 1'b1);
    chk("w1_chk_err", bus1.parity_err, 1'b1);
    chk("w1_chk_cnt", bus1.err_count, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
